// File: rtl/i2c_master_byte_ctrl.sv
// ============================================================================
// i2c_master_byte_ctrl: single-byte I2C master sequencer driven by divider
// SCL-phase strobes (START, addr+R/W, ACK, one data byte, ACK/NACK, STOP).
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_master_byte_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_p,
  input  logic              scl_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              rw_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              sda_i,
  output logic              scl_o,
  output logic              sda_o,
  output logic              sda_oe,
  output logic              busy,
  output logic              done,
  output logic              ack_err,
  output logic [DATA_W-1:0] rdata
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_START, ST_ADDR, ST_ACK1, ST_DATA, ST_ACK2, ST_STOP
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rw;
  logic              r_ack;
  logic              r_armed;
  logic              r_pend;
  logic              r_pend_oe;
  logic              r_pend_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_wdata   <= '0;
      r_rw      <= 1'b0;
      r_ack     <= 1'b0;
      r_armed   <= 1'b0;
      r_pend    <= 1'b0;
      r_pend_oe <= 1'b0;
      r_pend_o  <= 1'b1;
      scl_o     <= 1'b1;
      sda_o     <= 1'b1;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_err   <= 1'b0;
      rdata     <= '0;
    end else begin
      done <= 1'b0;
      // SDA updates requested on scl_n land one clk later, after SCL has fallen
      if (r_pend) begin
        sda_oe <= r_pend_oe;
        sda_o  <= r_pend_o;
        r_pend <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          scl_o  <= 1'b1;
          sda_o  <= 1'b1;
          r_pend <= 1'b0;
          if (start_i) begin
            r_tx    <= DATA_W'({addr_i, rw_i});
            r_wdata <= wdata_i;
            r_rw    <= rw_i;
            busy    <= 1'b1;
            ack_err <= 1'b0;
            sda_oe  <= 1'b1;
            r_armed <= 1'b0;
            r_state <= ST_WAIT_START;
          end else begin
            sda_oe <= 1'b0;
          end
        end

        ST_WAIT_START: begin
          if (scl_p) begin
            sda_o   <= 1'b0;
            r_armed <= 1'b1;
          end else if (scl_n && r_armed) begin
            scl_o     <= 1'b0;
            r_pend    <= 1'b1;
            r_pend_oe <= 1'b1;
            r_pend_o  <= r_tx[DATA_W-1];
            r_bit_cnt <= c_cnt_max;
            r_armed   <= 1'b0;
            r_state   <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (scl_p) begin
            scl_o <= 1'b1;
          end else if (scl_n) begin
            scl_o  <= 1'b0;
            r_pend <= 1'b1;
            if (r_bit_cnt == '0) begin
              r_pend_oe <= 1'b0;
              r_pend_o  <= 1'b1;
              r_state   <= ST_ACK1;
            end else begin
              r_bit_cnt <= r_bit_cnt - c_cnt_one;
              r_pend_oe <= 1'b1;
              r_pend_o  <= r_tx[DATA_W-2];
              r_tx      <= r_tx << 1;
            end
          end
        end

        ST_ACK1: begin
          if (scl_p) begin
            scl_o <= 1'b1;
            r_ack <= sda_i;
          end else if (scl_n) begin
            scl_o <= 1'b0;
            if (r_ack) begin
              ack_err   <= 1'b1;
              r_pend    <= 1'b1;
              r_pend_oe <= 1'b1;
              r_pend_o  <= 1'b0;
              r_armed   <= 1'b0;
              r_state   <= ST_STOP;
            end else begin
              r_bit_cnt <= c_cnt_max;
              r_state   <= ST_DATA;
              if (!r_rw) begin
                r_tx      <= r_wdata;
                r_pend    <= 1'b1;
                r_pend_oe <= 1'b1;
                r_pend_o  <= r_wdata[DATA_W-1];
              end
            end
          end
        end

        ST_DATA: begin
          if (scl_p) begin
            scl_o <= 1'b1;
            if (r_rw) r_rx <= {r_rx[DATA_W-2:0], sda_i};
          end else if (scl_n) begin
            scl_o <= 1'b0;
            if (r_bit_cnt == '0) begin
              // read ends with a master NACK, write releases for the slave ACK
              r_pend    <= 1'b1;
              r_pend_oe <= r_rw;
              r_pend_o  <= 1'b1;
              r_state   <= ST_ACK2;
            end else begin
              r_bit_cnt <= r_bit_cnt - c_cnt_one;
              if (!r_rw) begin
                r_pend    <= 1'b1;
                r_pend_oe <= 1'b1;
                r_pend_o  <= r_tx[DATA_W-2];
                r_tx      <= r_tx << 1;
              end
            end
          end
        end

        ST_ACK2: begin
          if (scl_p) begin
            scl_o <= 1'b1;
            if (!r_rw && sda_i) ack_err <= 1'b1;
          end else if (scl_n) begin
            scl_o     <= 1'b0;
            r_pend    <= 1'b1;
            r_pend_oe <= 1'b1;
            r_pend_o  <= 1'b0;
            r_armed   <= 1'b0;
            r_state   <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (scl_p) begin
            scl_o   <= 1'b1;
            r_armed <= 1'b1;
          end else if (scl_n && r_armed) begin
            sda_o   <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_armed <= 1'b0;
            r_state <= ST_IDLE;
            if (r_rw) rdata <= r_rx;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
